soc_system_adc_ltc2308_ctrl: RTL and testbench
==============================================

// Module: soc_system_adc_ltc2308_ctrl
// PURPOSE
//  Downstream consumer of the 3-bit ADC channel-select PIO (its out_port drives sel_channel).
//  Runs one LTC2308 SPI conversion on the selected single-ended channel when software starts it.
//  Exposes status and the 12-bit result as an Avalon-MM slave in soc_system, next to the PIO.
// PARAMETERS
//  CLK_DIV      2   SCK half-period in clk cycles; SCK = clk/(2*CLK_DIV); legal >=1
//  CONVST_CYC   2   CONVST high-pulse width in clk cycles; legal >=1
//  CONV_CYC     80  wait after CONVST falls, covers tCONV (1.6us at 50MHz); legal >=1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  sel_channel  in   3   channel select from the PIO out_port
//  address      in   2   Avalon word address
//  chipselect   in   1   Avalon select
//  read         in   1   Avalon read strobe; zero wait states
//  write_n      in   1   Avalon write strobe, active low
//  writedata    in   32  Avalon write data
//  readdata     out  32  Avalon read data, combinational from address
//  adc_convst   out  1   LTC2308 CONVST
//  adc_sck      out  1   LTC2308 SCK; idles low
//  adc_sdi      out  1   LTC2308 SDI (config word)
//  adc_sdo      in   1   LTC2308 SDO (result)
// BEHAVIOUR
//  Register map:
//   - addr0 W: any write starts a conversion.
//   - addr0 R: {30'b0, valid, busy}.
//   - addr1 R: {16'b0, valid, ch_tag[2:0], result[11:0]}.
//   - addr2, addr3 read 0; writes to addr1-3 are ignored.
//  Reset: FSM=IDLE. adc_convst, adc_sck, adc_sdi = 0. busy, valid, ch_tag, result = 0.
//   Reset mid-operation aborts the frame immediately; no partial result is kept.
//  Start = chipselect & ~write_n & address==0.
//   - In IDLE: latch ch_tag <= sel_channel, clear valid; busy=1 from next cycle.
//   - When busy: ignored. sel_channel changes while busy have no effect.
//  Every conversion runs 2 frames. Frame 1 loads the config word; frame 2 converts ch_tag and returns its data.
//  FSM per frame: CONVST -> CONV_WAIT -> SHIFT. After frame 2: DONE -> IDLE.
//   - CONVST: adc_convst=1 for CONVST_CYC cycles.
//   - CONV_WAIT: adc_convst=0 for CONV_CYC cycles.
//   - SHIFT: 12 SCK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
//     - adc_sdi is updated on the first low cycle of each period.
//     - adc_sdo is sampled on the first high cycle, MSB first, into a 12-bit shift register.
//     - adc_sdi = cfg[5:0], MSB first, then 0 for bits 6-11.
//     - cfg = {1'b1, ch_tag[0], ch_tag[2], ch_tag[1], 1'b1, 1'b0} (S/D, O/S, S1, S0, UNI, SLP).
//   - DONE (1 cycle): result <= shift register, valid <= 1, busy <= 0.
//  Latency: start write at cycle T; valid=1 and busy=0 visible at T+1+2*(CONVST_CYC+CONV_CYC+24*CLK_DIV).
//   With defaults this is T+261.
//  Frame-1 SDO data is discarded. Unsigned straight binary; no arithmetic is applied to the result.
//  A read of addr1 clears valid on the next cycle. If DONE occurs in the same cycle, the set wins.
//  readdata is valid in the cycle of read; it has no side effects other than clearing valid.
// CONFIGURATION
//  ADC_AUTO_RUN_EN defined:
//   - After DONE the FSM re-enters CONVST on the next cycle, re-latches ch_tag <= sel_channel, and busy stays 1.
//   - Each new result overwrites result and sets valid.
//   - A start write is a no-op while running. Auto-run begins one cycle after reset deasserts.
//   - If sel_channel changes, the next completed conversion reflects it.
//  ADC_AUTO_RUN_EN undefined: a conversion runs only on a software start; FSM idles otherwise.
// TESTING
//  1. Reset, sel_channel=3'd5, write addr0 -> SDI frame bits 1,1,1,0,1,0; busy=1.
//     Model returns 12'hA5C in frame 2 -> addr1 reads 0x0000_DA5C at T+261.
//  2. Second start while busy (T+50) -> ignored; exactly 2 CONVST pulses. Change sel_channel mid-run -> ch_tag unchanged.
//  3. Read addr1 in the same cycle as DONE -> valid=1 afterwards.
//     Read again -> valid=0; addr0 reads 0x0.
//  4. Assert reset during SHIFT of frame 2 -> next cycle convst/sck/sdi=0, busy=0, result=0, valid=0.
//     A fresh start completes normally.
//  5. CLK_DIV=1, CONV_CYC=4, CONVST_CYC=1 -> SCK=clk/2; valid at T+1+2*(1+4+24)=T+59.
//  6. ADC_AUTO_RUN_EN: sel_channel 0 then 7 -> successive results tagged 0 then 7.
//     CONVST pulses recur every 2*(CONVST_CYC+CONV_CYC+24*CLK_DIV)+1 cycles.

Source files
------------

// File: rtl/soc_system_adc_ltc2308_ctrl.sv
// LTC2308 SPI conversion controller with an Avalon-MM status/result slave.
// Optional free-running mode: define ADC_AUTO_RUN_EN.
module soc_system_adc_ltc2308_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int CONVST_CYC = 2,
    parameter int CONV_CYC   = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sel_channel,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int CNT_MAX = (CONV_CYC > CONVST_CYC)
                           ? ((CONV_CYC > CLK_DIV) ? CONV_CYC : CLK_DIV)
                           : ((CONVST_CYC > CLK_DIV) ? CONVST_CYC : CLK_DIV);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_CONV_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         r_bit;
    logic [3:0]         w_bit_nxt;
    logic               r_sck_hi;
    logic               w_sck_hi_nxt;
    logic               r_frame;
    logic               w_frame_nxt;
    logic               w_launch;
    logic               w_finish;

    logic [2:0]         r_ch_tag;
    logic [11:0]        r_result;
    logic [11:0]        r_shreg;
    logic [11:0]        w_shreg_nxt;
    logic               r_valid;
    logic               r_busy;

    logic               w_start;
    logic               w_go;
    logic               w_rd_res;
    logic               w_sample;
    logic [11:0]        w_sdi_word;
    logic [3:0]         w_bit_idx;
    logic               w_unused;

    assign w_start  = chipselect & ~write_n & (address == 2'd0);
    assign w_rd_res = chipselect & read & (address == 2'd1);
    assign w_unused = ^writedata;

`ifdef ADC_AUTO_RUN_EN
    assign w_go = 1'b1;
`else
    assign w_go = w_start;
`endif

    // Config word: S/D, O/S, S1, S0, UNI, SLP, then six zero bits.
    assign w_sdi_word = {1'b1, r_ch_tag[0], r_ch_tag[2], r_ch_tag[1], 1'b1, 1'b0, 6'b0};
    assign w_bit_idx  = 4'd11 - r_bit;
    assign w_sample   = (r_state == S_SHIFT) && r_sck_hi && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_shreg_nxt = w_sample ? {r_shreg[10:0], adc_sdo} : r_shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sck_hi <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_sck_hi <= w_sck_hi_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_sck_hi_nxt = r_sck_hi;
        w_frame_nxt  = r_frame;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        adc_convst   = 1'b0;
        adc_sck      = 1'b0;
        adc_sdi      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_state_nxt = S_CONVST;
                    w_cnt_nxt   = CNT_W'(CONVST_CYC - 1);
                    w_frame_nxt = 1'b0;
                    w_launch    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONVST: begin
                adc_convst = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_CONV_WAIT;
                    w_cnt_nxt   = CNT_W'(CONV_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_CONV_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_SHIFT;
                    w_cnt_nxt    = CNT_W'(CLK_DIV - 1);
                    w_bit_nxt    = 4'd0;
                    w_sck_hi_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_SHIFT: begin
                adc_sck = r_sck_hi;
                adc_sdi = w_sdi_word[w_bit_idx];
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!r_sck_hi) begin
                    w_sck_hi_nxt = 1'b1;
                    w_cnt_nxt    = CNT_W'(CLK_DIV - 1);
                end else if (r_bit != 4'd11) begin
                    w_bit_nxt    = r_bit + 4'd1;
                    w_sck_hi_nxt = 1'b0;
                    w_cnt_nxt    = CNT_W'(CLK_DIV - 1);
                end else if (!r_frame) begin
                    // Config frame done; second frame converts and returns data.
                    w_state_nxt  = S_CONVST;
                    w_frame_nxt  = 1'b1;
                    w_sck_hi_nxt = 1'b0;
                    w_cnt_nxt    = CNT_W'(CONVST_CYC - 1);
                end else begin
                    w_state_nxt  = S_DONE;
                    w_sck_hi_nxt = 1'b0;
                    w_finish     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result registers update on the edge that enters DONE, so DONE already shows them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch_tag <= 3'd0;
            r_result <= 12'd0;
            r_shreg  <= 12'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_shreg <= w_shreg_nxt;
            if (w_launch) begin
                r_ch_tag <= sel_channel;
                r_busy   <= 1'b1;
            end
`ifndef ADC_AUTO_RUN_EN
            if (w_launch) begin
                r_valid <= 1'b0;
            end
`endif
            if (w_rd_res) begin
                r_valid <= 1'b0;
            end
            if (w_finish) begin
                r_result <= w_shreg_nxt;
                r_valid  <= 1'b1;
`ifdef ADC_AUTO_RUN_EN
                r_busy   <= 1'b1;
`else
                r_busy   <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {30'd0, r_valid, r_busy};
            2'd1:    readdata = {16'd0, r_valid, r_ch_tag, r_result};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_adc_ltc2308_ctrl.sv
// Bench: two DUT instances (default and fast timing) driven against a behavioural LTC2308 model.
module tb_soc_system_adc_ltc2308_ctrl;

    localparam int D0 = 2, C0 = 2, V0 = 80;
    localparam int D1 = 1, C1 = 1, V1 = 4;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic [2:0]  sel    [2];
    logic [1:0]  addr   [2];
    logic        cs     [2];
    logic        rd     [2];
    logic        wr_n   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        convst [2];
    logic        sck    [2];
    logic        sdi    [2];
    logic        sdo_m  [2];

    int total = 0;
    int bad   = 0;

    // LTC2308 model state
    logic [11:0] mdl_data [2];
    logic [11:0] word     [2];
    int          n_cst    [2];
    int          cur_fr   [2];
    int          kb       [2];
    int          cst_run  [2];
    int          cst_len  [2];
    logic [11:0] sdi_cap  [2][2];
    int          rises    [2][2];
    logic        pc       [2];
    logic        ps       [2];

    always #5 clk = ~clk;

    soc_system_adc_ltc2308_ctrl #(.CLK_DIV(D0), .CONVST_CYC(C0), .CONV_CYC(V0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .sel_channel(sel[0]), .address(addr[0]),
        .chipselect(cs[0]), .read(rd[0]), .write_n(wr_n[0]), .writedata(wdata[0]),
        .readdata(rdata[0]), .adc_convst(convst[0]), .adc_sck(sck[0]),
        .adc_sdi(sdi[0]), .adc_sdo(sdo_m[0])
    );

    soc_system_adc_ltc2308_ctrl #(.CLK_DIV(D1), .CONVST_CYC(C1), .CONV_CYC(V1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .sel_channel(sel[1]), .address(addr[1]),
        .chipselect(cs[1]), .read(rd[1]), .write_n(wr_n[1]), .writedata(wdata[1]),
        .readdata(rdata[1]), .adc_convst(convst[1]), .adc_sck(sck[1]),
        .adc_sdi(sdi[1]), .adc_sdo(sdo_m[1])
    );

    // ADC: SDO presents MSB after CONVST, advances on each SCK fall; SDI captured on SCK rise.
    initial begin
        for (int i = 0; i < 2; i++) begin
            n_cst[i] = 0; cur_fr[i] = 0; kb[i] = 0; cst_run[i] = 0; cst_len[i] = 0;
            pc[i] = 1'b0; ps[i] = 1'b0; sdo_m[i] = 1'b0; word[i] = 12'd0; mdl_data[i] = 12'd0;
            sdi_cap[i][0] = 12'd0; sdi_cap[i][1] = 12'd0; rises[i][0] = 0; rises[i][1] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst[i]) begin
                    n_cst[i] = 0; kb[i] = 0; pc[i] = 1'b0; ps[i] = 1'b0; sdo_m[i] = 1'b0;
                    cst_run[i] = 0;
                end else begin
                    if (!sck[i] && ps[i]) begin
                        kb[i] = kb[i] + 1;
                        sdo_m[i] = (kb[i] < 12) ? word[i][11 - kb[i]] : 1'b0;
                    end
                    if (convst[i] && !pc[i]) begin
                        n_cst[i] = n_cst[i] + 1;
                        cur_fr[i] = (n_cst[i] % 2 == 1) ? 0 : 1;
                        word[i] = (cur_fr[i] == 1) ? mdl_data[i] : 12'($urandom);
                        kb[i] = 0;
                        sdo_m[i] = word[i][11];
                        sdi_cap[i][cur_fr[i]] = 12'd0;
                        rises[i][cur_fr[i]] = 0;
                        cst_run[i] = 1;
                    end else if (convst[i]) begin
                        cst_run[i] = cst_run[i] + 1;
                    end
                    if (!convst[i] && pc[i]) cst_len[i] = cst_run[i];
                    if (sck[i] && !ps[i]) begin
                        sdi_cap[i][cur_fr[i]] = {sdi_cap[i][cur_fr[i]][10:0], sdi[i]};
                        rises[i][cur_fr[i]] = rises[i][cur_fr[i]] + 1;
                    end
                    pc[i] = convst[i];
                    ps[i] = sck[i];
                end
            end
        end
    end

    function automatic int exp_lat(input int i);
        return (i == 0) ? 1 + 2 * (C0 + V0 + 24 * D0) : 1 + 2 * (C1 + V1 + 24 * D1);
    endfunction

    function automatic logic [31:0] res_word(input logic [2:0] tag, input logic [11:0] d);
        return {16'h0, 1'b1, tag, d};
    endfunction

    function automatic logic [11:0] sdi_word(input logic [2:0] tag);
        return {1'b1, tag[0], tag[2], tag[1], 1'b1, 1'b0, 6'b0};
    endfunction

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    task automatic peek(input int i, input logic [1:0] a, output logic [31:0] d);
        addr[i] = a;
        #1;
        d = rdata[i];
        addr[i] = 2'd0;
        #1;
    endtask

    task automatic rd_pulse(input int i, input logic [1:0] a);
        @(negedge clk);
        cs[i] = 1'b1; rd[i] = 1'b1; addr[i] = a;
        @(negedge clk);
        cs[i] = 1'b0; rd[i] = 1'b0; addr[i] = 2'd0;
        #1;
    endtask

    task automatic run_conv(input int i, input logic [2:0] tag, input logic [11:0] data,
                            input int coll_k, input int sel_k, input bit rd_done);
        int k, n0, el;
        logic [31:0] d;
        el = exp_lat(i);
        mdl_data[i] = data;
        sel[i] = tag;
        n0 = n_cst[i];
        @(negedge clk);
        addr[i] = 2'd0; cs[i] = 1'b1; wr_n[i] = 1'b0; wdata[i] = $urandom;
        k = 0;
        while (k < el + 20) begin
            @(negedge clk);
            k++;
            cs[i] = 1'b0; rd[i] = 1'b0; wr_n[i] = 1'b1; addr[i] = 2'd0;
            #1;
            if (k == 1) chk("busy_after_start", rdata[i], 32'h1);
            if (rdata[i][0] == 1'b0) break;
            if (k == coll_k) begin cs[i] = 1'b1; wr_n[i] = 1'b0; end
            if (k == sel_k) sel[i] = tag ^ 3'($urandom_range(1, 7));
            if (rd_done && k == el - 1) begin cs[i] = 1'b1; rd[i] = 1'b1; addr[i] = 2'd1; end
        end
        chk("latency", 32'(k), 32'(el));
        chk("convst_pulses", 32'(n_cst[i] - n0), 32'd2);
        chk("convst_width", 32'(cst_len[i]), 32'((i == 0) ? C0 : C1));
        chk("sdi_frame1", 32'(sdi_cap[i][0]), 32'(sdi_word(tag)));
        chk("sdi_frame2", 32'(sdi_cap[i][1]), 32'(sdi_word(tag)));
        chk("sck_frame1", 32'(rises[i][0]), 32'd12);
        chk("sck_frame2", 32'(rises[i][1]), 32'd12);
        peek(i, 2'd0, d);
        chk("status_done", d, 32'h2);
        peek(i, 2'd1, d);
        chk("result_word", d, res_word(tag, data));
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  t;
        logic [11:0] v;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; sel[i] = 3'd0; addr[i] = 2'd0; cs[i] = 1'b0;
            rd[i] = 1'b0; wr_n[i] = 1'b1; wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_pins", {29'd0, convst[i], sck[i], sdi[i]}, 32'd0);
            peek(i, 2'd0, d);
            chk("reset_status", d, 32'd0);
            peek(i, 2'd1, d);
            chk("reset_result", d, 32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        run_conv(0, 3'd5, 12'hA5C, 0, 0, 1'b0);
        peek(0, 2'd1, d);
        chk("t1_addr1", d, 32'h0000_DA5C);
        chk("t1_sdi", 32'(sdi_cap[0][0]), 32'h0000_0E80);
        peek(0, 2'd2, d);
        chk("addr2_zero", d, 32'd0);

        t = 3'($urandom); v = 12'($urandom);
        run_conv(0, t, v, 50, 100, 1'b0);

        t = 3'($urandom); v = 12'($urandom) | 12'h001;
        run_conv(0, t, v, 0, 0, 1'b1);
        rd_pulse(0, 2'd1);
        peek(0, 2'd0, d);
        chk("valid_cleared", d, 32'd0);

        // Reset in the middle of frame-2 shifting
        mdl_data[0] = 12'h3C3; sel[0] = 3'd6;
        @(negedge clk);
        cs[0] = 1'b1; wr_n[0] = 1'b0;
        @(negedge clk);
        cs[0] = 1'b0; wr_n[0] = 1'b1;
        repeat (exp_lat(0) - 40) @(negedge clk);
        chk("mid_shift", 32'((rises[0][1] > 0) && (rises[0][1] < 12)), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_pins", {29'd0, convst[0], sck[0], sdi[0]}, 32'd0);
        peek(0, 2'd0, d);
        chk("abort_status", d, 32'd0);
        peek(0, 2'd1, d);
        chk("abort_result", d, 32'd0);
        rst[0] = 1'b0;
        t = 3'($urandom); v = 12'($urandom);
        run_conv(0, t, v, 0, 0, 1'b0);

        for (int n = 0; n < 3; n++) begin
            t = 3'($urandom); v = 12'($urandom);
            run_conv(1, t, v, 0, 0, 1'b0);
        end
        for (int n = 0; n < 2; n++) begin
            t = 3'($urandom); v = 12'($urandom);
            run_conv(0, t, v, 30 + n * 40, 60 + n * 30, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
